// File: rtl/clk_sel_sched.sv
// Clock-mux select sequencer: manual req/ack switching or timed auto rotation.
// Define CLK_SEL_SCHED_STATUS_EN to add the switch_count status output.
module clk_sel_sched #(
    parameter int DWELL_W = 8,
    parameter int SETTLE  = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               mode,
    input  logic               req,
    input  logic [1:0]         req_sel,
    input  logic [DWELL_W-1:0] dwell,
    output logic [1:0]         select,
    output logic               gate,
    output logic               busy,
    output logic               ack
`ifdef CLK_SEL_SCHED_STATUS_EN
    ,
    output logic [7:0]         switch_count
`endif
);

    typedef enum logic [1:0] {
        S_STABLE,
        S_DRAIN,
        S_SETTLE
    } state_t;

    localparam logic [3:0] SETTLE_INIT = 4'(SETTLE - 1);

    state_t             state;
    logic [1:0]         target;
    logic               ack_pend;
    logic [3:0]         settle_cnt;
    logic [DWELL_W-1:0] dwell_cnt;

    logic [1:0] req_map;
    logic [1:0] next_sel;
    logic       man_sw;
    logic       man_nop;
    logic       auto_on;
    logic       auto_sw;

    always_comb begin
        req_map  = (req_sel == 2'd3) ? 2'd2 : req_sel;
        next_sel = (select == 2'd2) ? 2'd0 : select + 2'd1;
        man_sw   = req && (req_map != select);
        man_nop  = req && (req_map == select);
        auto_on  = mode && (dwell != '0);
        // >= rather than == so a shrunken dwell rotates at once
        auto_sw  = auto_on && !man_sw
                   && (dwell_cnt >= dwell - DWELL_W'(1));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_SETTLE;
            select     <= 2'd0;
            gate       <= 1'b0;
            busy       <= 1'b1;
            ack        <= 1'b0;
            target     <= 2'd0;
            ack_pend   <= 1'b0;
            settle_cnt <= SETTLE_INIT;
            dwell_cnt  <= '0;
        end else begin
            ack <= 1'b0;
            unique case (state)
                S_STABLE: begin
                    if (man_sw) begin
                        target   <= req_map;
                        ack_pend <= 1'b1;
                        state    <= S_DRAIN;
                        gate     <= 1'b0;
                        busy     <= 1'b1;
                    end else begin
                        if (man_nop)
                            ack <= 1'b1;
                        if (auto_sw) begin
                            target   <= next_sel;
                            ack_pend <= 1'b0;
                            state    <= S_DRAIN;
                            gate     <= 1'b0;
                            busy     <= 1'b1;
                        end else if (auto_on) begin
                            dwell_cnt <= dwell_cnt + DWELL_W'(1);
                        end
                    end
                end
                S_DRAIN: begin
                    select     <= target;
                    settle_cnt <= SETTLE_INIT;
                    state      <= S_SETTLE;
                end
                S_SETTLE: begin
                    if (settle_cnt == 4'd0) begin
                        state     <= S_STABLE;
                        gate      <= 1'b1;
                        busy      <= 1'b0;
                        ack       <= ack_pend;
                        ack_pend  <= 1'b0;
                        dwell_cnt <= '0;
                    end else begin
                        settle_cnt <= settle_cnt - 4'd1;
                    end
                end
                default: begin
                    state <= S_SETTLE;
                end
            endcase
        end
    end

`ifdef CLK_SEL_SCHED_STATUS_EN
    // Marks a settle that follows a real source change (not reset)
    logic switched;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            switched     <= 1'b0;
            switch_count <= 8'd0;
        end else if (state == S_DRAIN) begin
            switched <= 1'b1;
        end else if (state == S_SETTLE && settle_cnt == 4'd0) begin
            switched <= 1'b0;
            if (switched)
                switch_count <= switch_count + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_clk_sel_sched.sv
// Randomized and directed bench for clk_sel_sched against a timeline model.
// Honours CLK_SEL_SCHED_STATUS_EN for the switch_count output.
module tb_clk_sel_sched;

    localparam int SETTLE  = 4;
    localparam int DWELL_W = 8;

    logic               clk = 1'b0;
    logic               reset;
    logic               mode;
    logic               req;
    logic [1:0]         req_sel;
    logic [DWELL_W-1:0] dwell;
    logic [1:0]         select;
    logic               gate;
    logic               busy;
    logic               ack;
`ifdef CLK_SEL_SCHED_STATUS_EN
    logic [7:0]         switch_count;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    clk_sel_sched #(.DWELL_W(DWELL_W), .SETTLE(SETTLE)) dut (
        .clk(clk),
        .reset(reset),
        .mode(mode),
        .req(req),
        .req_sel(req_sel),
        .dwell(dwell),
        .select(select),
        .gate(gate),
        .busy(busy),
        .ack(ack)
`ifdef CLK_SEL_SCHED_STATUS_EN
        ,
        .switch_count(switch_count)
`endif
    );

    // Model: a switch is a timeline counted in edges since the decision.
    // Edge +1 moves select, edge +(SETTLE+1) restores gate and pays the ack.
    int m_sel, m_tgt, m_t, m_dw, m_cnt;
    bit m_gate, m_busy, m_ack, m_sw, m_pack, m_real;

    function automatic void model_reset();
        m_sel  = 0;
        m_tgt  = 0;
        m_t    = 1;
        m_dw   = 0;
        m_cnt  = 0;
        m_gate = 0;
        m_busy = 1;
        m_ack  = 0;
        m_sw   = 1;
        m_pack = 0;
        m_real = 0;
    endfunction

    function automatic void begin_switch(int tgt, bit manual);
        m_sw   = 1;
        m_t    = 0;
        m_tgt  = tgt;
        m_pack = manual;
        m_real = 1;
        m_gate = 0;
        m_busy = 1;
    endfunction

    function automatic void model_step();
        int r;
        if (reset) begin
            model_reset();
            return;
        end
        m_ack = 0;
        if (m_sw) begin
            m_t++;
            if (m_t == 1)
                m_sel = m_tgt;
            if (m_t == SETTLE + 1) begin
                m_sw   = 0;
                m_gate = 1;
                m_busy = 0;
                m_ack  = m_pack;
                m_pack = 0;
                m_dw   = 0;
                if (m_real)
                    m_cnt = (m_cnt + 1) % 256;
            end
        end else begin
            r = (req_sel == 2'd3) ? 2 : int'(req_sel);
            if (req && r != m_sel) begin
                begin_switch(r, 1);
            end else begin
                if (req)
                    m_ack = 1;
                if (mode && dwell != 0) begin
                    if (m_dw + 1 >= int'(dwell))
                        begin_switch((m_sel + 1) % 3, 0);
                    else
                        m_dw++;
                end
            end
        end
    endfunction

    task automatic tick();
        model_step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        model_reset();
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset   = 1'b1;
        mode    = 1'b0;
        req     = 1'b0;
        req_sel = 2'd0;
        dwell   = '0;
        model_reset();
        @(negedge clk);
        checks++;
        if (select !== 2'd0 || gate !== 1'b0 || busy !== 1'b1 || ack !== 1'b0) begin
            errors++;
            $display("FAIL reset_vals sel=%0d gate=%0b busy=%0b ack=%0b want 0 0 1 0",
                     select, gate, busy, ack);
        end
        reset = 1'b0;
        for (int i = 1; i <= SETTLE; i++) begin
            tick();
            checks++;
            if (select !== 2'd0 || gate !== (i == SETTLE) || busy !== (i != SETTLE)
                || ack !== 1'b0) begin
                errors++;
                $display("FAIL reset_release edge%0d sel=%0d gate=%0b busy=%0b ack=%0b",
                         i, select, gate, busy, ack);
            end
        end
    endtask

    task automatic test_manual();
        req     = 1'b1;
        req_sel = 2'd2;
        tick();
        checks++;
        if (gate !== 1'b0 || select !== 2'd0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL manual_e0 gate=%0b sel=%0d busy=%0b want 0 0 1", gate, select, busy);
        end
        for (int i = 1; i <= SETTLE; i++) begin
            tick();
            checks++;
            if (gate !== 1'b0 || select !== 2'd2 || ack !== 1'b0) begin
                errors++;
                $display("FAIL manual_settle e%0d gate=%0b sel=%0d ack=%0b want 0 2 0",
                         i, gate, select, ack);
            end
        end
        tick();
        checks++;
        if (gate !== 1'b1 || ack !== 1'b1 || select !== 2'd2 || busy !== 1'b0) begin
            errors++;
            $display("FAIL manual_done gate=%0b ack=%0b sel=%0d busy=%0b want 1 1 2 0",
                     gate, ack, select, busy);
        end
        req = 1'b0;
        tick();
        checks++;
        if (ack !== 1'b0 || gate !== 1'b1) begin
            errors++;
            $display("FAIL manual_ack_pulse ack=%0b gate=%0b want 0 1", ack, gate);
        end
    endtask

    task automatic test_noop();
        req     = 1'b1;
        req_sel = 2'd3;
        tick();
        checks++;
        if (ack !== 1'b1 || gate !== 1'b1 || select !== 2'd2) begin
            errors++;
            $display("FAIL noop ack=%0b gate=%0b sel=%0d want 1 1 2", ack, gate, select);
        end
        req = 1'b0;
        tick();
        checks++;
        if (ack !== 1'b0 || gate !== 1'b1 || select !== 2'd2) begin
            errors++;
            $display("FAIL noop_after ack=%0b gate=%0b sel=%0d want 0 1 2", ack, gate, select);
        end
    endtask

    task automatic test_auto();
        mode  = 1'b1;
        dwell = 8'd3;
        do_reset();
        for (int i = 0; i < SETTLE; i++)
            tick();
        for (int k = 0; k < 4; k++) begin
            for (int h = 0; h < 3; h++) begin
                checks++;
                if (gate !== 1'b1 || select !== 2'(k % 3) || ack !== 1'b0) begin
                    errors++;
                    $display("FAIL auto_high k%0d h%0d gate=%0b sel=%0d ack=%0b want 1 %0d 0",
                             k, h, gate, select, ack, k % 3);
                end
                tick();
            end
            for (int l = 0; l < SETTLE + 1; l++) begin
                checks++;
                if (gate !== 1'b0 || ack !== 1'b0) begin
                    errors++;
                    $display("FAIL auto_low k%0d l%0d gate=%0b ack=%0b want 0 0",
                             k, l, gate, ack);
                end
                tick();
            end
        end
        mode = 1'b0;
    endtask

    task automatic test_priority();
        mode  = 1'b1;
        dwell = 8'd1;
        req   = 1'b0;
        do_reset();
        for (int i = 0; i < SETTLE; i++)
            tick();
        req     = 1'b1;
        req_sel = 2'd2;
        for (int i = 0; i < SETTLE + 1; i++)
            tick();
        tick();
        checks++;
        if (select !== 2'd2 || ack !== 1'b1 || gate !== 1'b1) begin
            errors++;
            $display("FAIL priority sel=%0d ack=%0b gate=%0b want 2 1 1", select, ack, gate);
        end
`ifdef CLK_SEL_SCHED_STATUS_EN
        checks++;
        if (switch_count !== 8'd1) begin
            errors++;
            $display("FAIL priority_count got %0d want 1", switch_count);
        end
`endif
        req  = 1'b0;
        mode = 1'b0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 0; i < SETTLE; i++)
            tick();
        req     = 1'b1;
        req_sel = 2'd1;
        tick();
        tick();
        tick();
        checks++;
        if (select !== 2'd1 || gate !== 1'b0) begin
            errors++;
            $display("FAIL mid_pre sel=%0d gate=%0b want 1 0", select, gate);
        end
        reset = 1'b1;
        model_reset();
        req = 1'b0;
        #1;
        checks++;
        if (select !== 2'd0 || gate !== 1'b0 || ack !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL mid_reset sel=%0d gate=%0b ack=%0b busy=%0b want 0 0 0 1",
                     select, gate, ack, busy);
        end
`ifdef CLK_SEL_SCHED_STATUS_EN
        checks++;
        if (switch_count !== 8'd0) begin
            errors++;
            $display("FAIL mid_reset_count got %0d want 0", switch_count);
        end
`endif
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_random();
        mode  = 1'b0;
        dwell = 8'd2;
        req   = 1'b0;
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            tick();
            checks++;
            if (select !== 2'(m_sel) || gate !== m_gate || busy !== m_busy
                || ack !== m_ack) begin
                errors++;
                $display("FAIL random c%0d sel=%0d gate=%0b busy=%0b ack=%0b want %0d %0b %0b %0b",
                         c, select, gate, busy, ack, m_sel, m_gate, m_busy, m_ack);
            end
`ifdef CLK_SEL_SCHED_STATUS_EN
            checks++;
            if (switch_count !== 8'(m_cnt)) begin
                errors++;
                $display("FAIL random_count c%0d got %0d want %0d", c, switch_count, m_cnt);
            end
`endif
            if (req && m_ack)
                req = 1'b0;
            else if (!req && $urandom_range(0, 5) == 0) begin
                req     = 1'b1;
                req_sel = 2'($urandom_range(0, 3));
            end
            if ($urandom_range(0, 63) == 0)
                mode = ~mode;
            if ($urandom_range(0, 31) == 0)
                dwell = DWELL_W'($urandom_range(0, 6));
            if (reset)
                reset = 1'b0;
            else if ($urandom_range(0, 399) == 0) begin
                reset = 1'b1;
                model_reset();
            end
        end
        reset = 1'b0;
    endtask

    initial begin
        test_reset();
        test_manual();
        test_noop();
        test_auto();
        test_priority();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
